bb_pwm_multi: RTL and testbench
===============================

# bb_pwm_multi

Multi-channel, slew-limited PWM generator for the quadcopter ESC outputs, one channel per motor. All channels share one free-running frame counter. Each channel ramps its duty toward a commanded target by at most `ACC` per frame, and a global `arm` gate forces every output safe. It sits between the flight-control mixer, which writes all motor targets at once, and the ESC pins.

## Interface
- `N_CH`, 4: number of PWM channels.
- `CNT_W`, 16: counter and duty width.
- `CNT_STEP`, 256: counter increment per clock; frame length = 2^CNT_W / CNT_STEP cycles (256 by default).
- `MIN_SPEED`, 256: lowest duty value and reset/disarm duty.
- `MAX_SPEED`, 2^CNT_W-1: highest duty value; must be ≤ 2^CNT_W-1.
- `ACC`, 2560: maximum duty change per frame.
- `DEAD_ZONE`, ACC/2: snap band; when |target−duty| ≤ DEAD_ZONE, duty jumps straight to target.
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `arm` in 1: level; high enables outputs and command acceptance.
- `speed_in` in N_CH*CNT_W: packed targets; channel i occupies bits [i*CNT_W +: CNT_W].
- `speed_valid` in 1: the mixer offers a full target vector.
- `speed_ready` out 1: the block accepts targets (registered armed flag).
- `pwm_out` out N_CH: active-high PWM.
- `busy` out N_CH: the channel's duty differs from its target.
- `frame_tick` out 1: one-cycle pulse on the last cycle of each frame.

## Operation
- Counter `cnt` adds CNT_STEP every clock and wraps modulo 2^CNT_W.
- `frame_tick` = (cnt == 2^CNT_W − CNT_STEP).
- Capture: when `speed_valid && speed_ready`, all N_CH targets load in the same edge.
  - Each target is clamped to [MIN_SPEED, MAX_SPEED].
  - Capture is allowed while a channel is ramping (retarget mid-ramp); no other gating applies.
- Per-channel FSM:
  - IDLE: entered when duty == target.
  - RAMP: entered when duty ≠ target.
  - `busy[i]` = (state == RAMP).
- Duty update, applied only on a `frame_tick` edge, channels in RAMP:
  - diff > DEAD_ZONE: duty moves toward target by min(ACC, diff). It never overshoots and never leaves [MIN_SPEED, MAX_SPEED].
  - diff ≤ DEAD_ZONE: duty = target, and the FSM goes to IDLE.
- Arithmetic: sums and differences are computed at CNT_W+1 bits so nothing wraps.
- Output: `pwm_out[i]` = armed_q && (cnt < duty[i]).
- `arm` low: on the next edge, `speed_ready` → 0, every target and duty → MIN_SPEED, FSMs → IDLE, and `pwm_out` → 0 on that same edge.
- `arm` high: `speed_ready` rises on the next edge. `armed_q` for output gating rises only at the next `frame_tick`, so the first pulse is a whole frame.

## Timing
- Reset values:
  - cnt 0; every duty and target MIN_SPEED; armed_q 0.
  - `speed_ready` 0, `pwm_out` 0, `busy` 0, `frame_tick` 0.
- Target capture → `busy` high: 1 cycle.
- Capture → first duty change: the next `frame_tick`. If the capture coincides with a `frame_tick`, that tick ramps toward the old target.
- A new duty takes effect at cnt = 0 of the following frame, so pulses never glitch mid-frame.
- `busy[i]` falls on the `frame_tick` edge that makes duty == target.
- `rst` mid-ramp: immediately returns all state to reset values; there is no completion of the frame.
- `speed_valid` while `speed_ready` = 0: ignored; nothing is queued.

## Configuration
- `BB_PWM_RAMP_EN` defined: slew-limited ramp as described above.
- `BB_PWM_RAMP_EN` undefined:
  - On each `frame_tick`, duty = target directly, so each change lands in one frame.
  - ACC and DEAD_ZONE are unused.
  - `busy[i]` is high from capture until that tick.

## Structure
- Package `bb_pwm_pkg`:
  - the `ch_state_t` enum {CH_IDLE, CH_RAMP};
  - default constants for MIN_SPEED, ACC and CNT_STEP;
  - a `clamp_speed` function.
- Sub-module `bb_pwm_ramp_ch` holds one channel's target/duty registers, FSM, ramp arithmetic and output comparator. It is instantiated N_CH times in a generate loop.
- The top level holds the counter, the `frame_tick` decode, the arm logic and the handshake.

## Test plan
- Reset, then raise arm: `speed_ready` = 1 after 1 cycle; `pwm_out` stays 0 until after the first `frame_tick`, then each channel is high for 1 cycle per 256-cycle frame (duty 256).
- Ch0 target 30000 from 256: duty steps 2816, 5376, … 28416 (frame 11), then 30000 at frame 12; `busy[0]` falls on the 12th tick.
- Target 1000 with duty 256 (diff 744 ≤ 1280): duty snaps to 1000 at the next tick; `busy` is high for that frame only.
- Retarget mid-ramp from duty 10496, target 60000 → 5000: the next ticks give 7936, then 5376, then 5000.
- Drop arm mid-ramp: `pwm_out` = 0 and duty = 256 on the next edge; `speed_valid` with 40000 is ignored while disarmed.
- Target 0xFFFF with MAX_SPEED 60000: the captured target is 60000; the ramp settles at 60000 with no wrap.

Source files
------------

// File: rtl/bb_pwm_pkg.sv
// ============================================================================
// Module      : bb_pwm_pkg
// Description : Shared channel state type, default constants and target clamp
//               for the bb_pwm_multi ESC PWM generator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bb_pwm_pkg;

  typedef enum logic [0:0] {
    CH_IDLE = 1'b0,
    CH_RAMP = 1'b1
  } ch_state_t;

  localparam int c_MIN_SPEED = 256;
  localparam int c_ACC       = 2560;
  localparam int c_CNT_STEP  = 256;

  function automatic logic [31:0] clamp_speed(input logic [31:0] val,
                                              input logic [31:0] lo,
                                              input logic [31:0] hi);
    logic [31:0] res;
    res = val;
    if (val < lo) begin
      res = lo;
    end else if (val > hi) begin
      res = hi;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bb_pwm_ramp_ch.sv
// ============================================================================
// Module      : bb_pwm_ramp_ch
// Description : One PWM channel: target/duty registers, IDLE/RAMP FSM, slew
//               step and output comparator. BB_PWM_RAMP_EN selects the
//               slew-limited ramp; otherwise duty jumps to target per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bb_pwm_ramp_ch
  import bb_pwm_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int MIN_SPEED = c_MIN_SPEED,
  parameter int MAX_SPEED = 65535
`ifdef BB_PWM_RAMP_EN
  ,
  parameter int ACC       = c_ACC,
  parameter int DEAD_ZONE = c_ACC / 2
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             capture_i,
  input  logic             disarm_i,
  input  logic             armed_i,
  input  logic [CNT_W-1:0] speed_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             pwm_o,
  output logic             busy_o
);

  localparam logic [CNT_W-1:0] c_MIN = CNT_W'(MIN_SPEED);

  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] w_duty_step;
  ch_state_t        state_q, state_d;

`ifdef BB_PWM_RAMP_EN
  localparam logic [CNT_W:0] c_ACC_X = (CNT_W+1)'(ACC);
  localparam logic [CNT_W:0] c_DZ_X  = (CNT_W+1)'(DEAD_ZONE);

  logic [CNT_W:0] w_tgt_x, w_duty_x, w_diff, w_step;
  logic           w_up;

  // One extra bit keeps the difference and the stepped duty from wrapping.
  always_comb begin
    w_tgt_x  = {1'b0, target_q};
    w_duty_x = {1'b0, duty_q};
    w_up     = (w_tgt_x > w_duty_x);
    w_diff   = w_up ? (w_tgt_x - w_duty_x) : (w_duty_x - w_tgt_x);
    w_step   = (w_diff > c_ACC_X) ? c_ACC_X : w_diff;
    if (w_diff <= c_DZ_X) begin
      w_duty_step = target_q;
    end else if (w_up) begin
      w_duty_step = CNT_W'(w_duty_x + w_step);
    end else begin
      w_duty_step = CNT_W'(w_duty_x - w_step);
    end
  end
`else
  assign w_duty_step = target_q;
`endif

  // The step uses the pre-capture target, so a capture on a tick edge
  // only affects the following frame.
  always_comb begin
    target_d = target_q;
    duty_d   = duty_q;
    state_d  = state_q;
    if (disarm_i) begin
      target_d = c_MIN;
      duty_d   = c_MIN;
      state_d  = CH_IDLE;
    end else begin
      if (tick_i && (state_q == CH_RAMP)) begin
        duty_d = w_duty_step;
      end
      if (capture_i) begin
        target_d = CNT_W'(clamp_speed(32'(speed_i), 32'(MIN_SPEED), 32'(MAX_SPEED)));
      end
      state_d = (duty_d != target_d) ? CH_RAMP : CH_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q <= c_MIN;
      duty_q   <= c_MIN;
      state_q  <= CH_IDLE;
    end else begin
      target_q <= target_d;
      duty_q   <= duty_d;
      state_q  <= state_d;
    end
  end

  assign busy_o = (state_q == CH_RAMP);
  assign pwm_o  = armed_i && (cnt_i < duty_q);

endmodule

`default_nettype wire

// File: rtl/bb_pwm_multi.sv
// ============================================================================
// Module      : bb_pwm_multi
// Description : Multi-channel slew-limited ESC PWM generator: shared frame
//               counter, frame tick, arm gating and target handshake.
//               Macro BB_PWM_RAMP_EN enables the per-frame slew limit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bb_pwm_multi
  import bb_pwm_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 16,
  parameter int CNT_STEP  = c_CNT_STEP,
  parameter int MIN_SPEED = c_MIN_SPEED,
  parameter int MAX_SPEED = (1 << CNT_W) - 1
`ifdef BB_PWM_RAMP_EN
  ,
  parameter int ACC       = c_ACC,
  parameter int DEAD_ZONE = ACC / 2
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [N_CH*CNT_W-1:0] speed_in,
  input  logic                  speed_valid,
  output logic                  speed_ready,
  output logic [N_CH-1:0]       pwm_out,
  output logic [N_CH-1:0]       busy,
  output logic                  frame_tick
);

  localparam logic [CNT_W-1:0] c_STEP = CNT_W'(CNT_STEP);
  localparam logic [CNT_W-1:0] c_LAST = {CNT_W{1'b0}} - c_STEP;

  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             armed_q;
  logic             w_tick;
  logic             w_capture;
  logic             w_disarm;

  assign w_tick    = (cnt_q == c_LAST);
  assign w_capture = speed_valid && ready_q;
  assign w_disarm  = !arm;

  // Output gating waits for a frame boundary so the first pulse is whole.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      ready_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_q + c_STEP;
      ready_q <= arm;
      armed_q <= arm && (armed_q || w_tick);
    end
  end

  assign speed_ready = ready_q;
  assign frame_tick  = w_tick;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    bb_pwm_ramp_ch #(
      .CNT_W     (CNT_W),
      .MIN_SPEED (MIN_SPEED),
      .MAX_SPEED (MAX_SPEED)
`ifdef BB_PWM_RAMP_EN
      ,
      .ACC       (ACC),
      .DEAD_ZONE (DEAD_ZONE)
`endif
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .tick_i    (w_tick),
      .capture_i (w_capture),
      .disarm_i  (w_disarm),
      .armed_i   (armed_q),
      .speed_i   (speed_in[i*CNT_W +: CNT_W]),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_out[i]),
      .busy_o    (busy[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_bb_pwm_multi.sv
// ============================================================================
// Module      : tb_bb_pwm_multi
// Description : Self-checking bench for bb_pwm_multi: frame-level reference
//               model, directed pulse-width scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bb_pwm_multi;

  localparam int N_CH    = 4;
  localparam int CNT_W   = 16;
  localparam int STEP    = 256;
  localparam int MIN_SPD = 256;
  localparam int MAX_SPD = 60000;
  localparam int ACC     = 2560;
  localparam int DZ      = 1280;
  localparam int LAST    = 65536 - STEP;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  arm = 1'b0;
  logic                  speed_valid = 1'b0;
  logic [N_CH*CNT_W-1:0] speed_in = '0;
  logic                  speed_ready;
  logic [N_CH-1:0]       pwm_out;
  logic [N_CH-1:0]       busy;
  logic                  frame_tick;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int wid[N_CH];

  always #5 clk = ~clk;

  bb_pwm_multi #(
    .N_CH      (N_CH),
    .CNT_W     (CNT_W),
    .CNT_STEP  (STEP),
    .MIN_SPEED (MIN_SPD),
    .MAX_SPEED (MAX_SPD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .arm         (arm),
    .speed_in    (speed_in),
    .speed_valid (speed_valid),
    .speed_ready (speed_ready),
    .pwm_out     (pwm_out),
    .busy        (busy),
    .frame_tick  (frame_tick)
  );

  // Reference model: frame-level arithmetic on plain integers.
  int m_cnt = 0;
  bit m_ready = 1'b0;
  bit m_armed = 1'b0;
  int m_tgt[N_CH]  = '{default: MIN_SPD};
  int m_duty[N_CH] = '{default: MIN_SPD};

  function automatic int clampv(input int v);
    return (v < MIN_SPD) ? MIN_SPD : ((v > MAX_SPD) ? MAX_SPD : v);
  endfunction

  function automatic int next_duty(input int d, input int t);
`ifdef BB_PWM_RAMP_EN
    int diff;
    int stp;
    diff = (t > d) ? t - d : d - t;
    if (diff <= DZ) return t;
    stp = (diff < ACC) ? diff : ACC;
    return (t > d) ? d + stp : d - stp;
`else
    return t;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt   = 0;
      m_ready = 1'b0;
      m_armed = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        m_tgt[i]  = MIN_SPD;
        m_duty[i] = MIN_SPD;
      end
    end else begin
      bit tick;
      bit cap;
      tick = (m_cnt == LAST);
      cap  = speed_valid && m_ready;
      if (!arm) begin
        m_ready = 1'b0;
        m_armed = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          m_tgt[i]  = MIN_SPD;
          m_duty[i] = MIN_SPD;
        end
      end else begin
        for (int i = 0; i < N_CH; i++) begin
          if (tick) m_duty[i] = next_duty(m_duty[i], m_tgt[i]);
          if (cap) m_tgt[i] = clampv(int'(speed_in[i*CNT_W +: CNT_W]));
        end
        if (tick) m_armed = 1'b1;
        m_ready = 1'b1;
      end
      m_cnt = (m_cnt + STEP) % 65536;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("speed_ready", 32'(speed_ready), 32'(m_ready));
      check("frame_tick", 32'(frame_tick), 32'(m_cnt == LAST));
      for (int i = 0; i < N_CH; i++) begin
        check($sformatf("pwm_out[%0d]", i), 32'(pwm_out[i]), 32'(m_armed && (m_cnt < m_duty[i])));
        check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_duty[i] != m_tgt[i]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    step();
    while (frame_tick !== 1'b1 && k < 600) begin
      step();
      k++;
    end
    check("tick_timeout", 32'(frame_tick), 32'd1);
  endtask

  // Called on a tick cycle; counts high cycles of every channel over the
  // following frame and ends on the next tick cycle.
  task automatic measure(input int ch, input int exp, input string name);
    for (int i = 0; i < N_CH; i++) wid[i] = 0;
    repeat (STEP) begin
      step();
      for (int i = 0; i < N_CH; i++) wid[i] += int'(pwm_out[i]);
    end
    check(name, 32'(wid[ch]), 32'(exp));
  endtask

  task automatic capture(input int a, input int b, input int c, input int d);
    speed_in    = {16'(d), 16'(c), 16'(b), 16'(a)};
    speed_valid = 1'b1;
    step();
    speed_valid = 1'b0;
  endtask

  initial begin
    repeat (3) step();
    check("rst_ready", 32'(speed_ready), 32'd0);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    chk_en = 1'b1;
    rst    = 1'b0;
    arm    = 1'b1;
    step();
    check("ready_after_arm", 32'(speed_ready), 32'd1);
    wait_tick();
    check("pwm_before_armed", 32'(pwm_out), 32'd0);
    measure(0, 1, "first_frame_ch0");
    for (int i = 1; i < N_CH; i++) check($sformatf("first_frame_ch%0d", i), 32'(wid[i]), 32'd1);

    // Small move snaps within one frame.
    step();
    capture(256, 1000, 256, 256);
    check("snap_busy_set", 32'(busy[1]), 32'd1);
    wait_tick();
    measure(1, 4, "snap_width");
    check("snap_busy_clr", 32'(busy[1]), 32'd0);

    // Long ramp 256 -> 30000.
    step();
    capture(30000, 1000, 256, 256);
    wait_tick();
`ifdef BB_PWM_RAMP_EN
    for (int k = 1; k <= 11; k++) measure(0, 1 + 10 * k, $sformatf("ramp_frame%0d", k));
    check("ramp_busy_before_last", 32'(busy[0]), 32'd1);
`endif
    measure(0, 118, "ramp_final");
    check("ramp_busy_done", 32'(busy[0]), 32'd0);

    // 0xFFFF request clamps to MAX_SPEED without wrapping.
    step();
    capture(30000, 1000, 256, 65535);
    wait_tick();
`ifdef BB_PWM_RAMP_EN
    for (int k = 1; k <= 23; k++) measure(3, 1 + 10 * k, $sformatf("clamp_frame%0d", k));
`endif
    measure(3, 235, "clamp_final");
    check("clamp_busy_done", 32'(busy[3]), 32'd0);

    // Retarget while ramping.
    step();
    capture(30000, 1000, 60000, 60000);
    wait_tick();
`ifdef BB_PWM_RAMP_EN
    measure(2, 11, "retgt_up1");
    measure(2, 21, "retgt_up2");
    measure(2, 31, "retgt_up3");
    step();
    capture(30000, 1000, 5000, 60000);
    wait_tick();
    measure(2, 31, "retgt_dn1");
    measure(2, 21, "retgt_dn2");
`else
    measure(2, 235, "retgt_up");
    step();
    capture(30000, 1000, 5000, 60000);
    wait_tick();
`endif
    measure(2, 20, "retgt_final");
    check("retgt_busy_done", 32'(busy[2]), 32'd0);

    // Disarm mid-ramp; commands while disarmed are dropped.
    step();
    capture(30000, 40000, 5000, 60000);
    wait_tick();
    repeat (10) step();
    arm = 1'b0;
    step();
    check("disarm_pwm", 32'(pwm_out), 32'd0);
    check("disarm_busy", 32'(busy), 32'd0);
    check("disarm_ready", 32'(speed_ready), 32'd0);
    speed_in    = {4{16'd40000}};
    speed_valid = 1'b1;
    repeat (5) step();
    speed_valid = 1'b0;
    check("disarm_ignored", 32'(busy), 32'd0);
    arm = 1'b1;
    wait_tick();
    measure(1, 1, "rearm_duty_min");
    check("rearm_busy", 32'(busy), 32'd0);

    // Reset mid-ramp clears immediately.
    step();
    capture(50000, 50000, 50000, 50000);
    wait_tick();
    repeat (20) step();
    rst = 1'b1;
    #1;
    check("midrst_pwm", 32'(pwm_out), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(speed_ready), 32'd0);
    step();
    rst = 1'b0;
    step();
    check("postrst_ready", 32'(speed_ready), 32'd1);

    // Random traffic against the model.
    repeat (15000) begin
      step();
      speed_valid = ($urandom_range(0, 15) == 0);
      if (speed_valid) begin
        for (int i = 0; i < N_CH; i++) begin
          case ($urandom_range(0, 3))
            0:       speed_in[i*CNT_W +: CNT_W] = 16'($urandom_range(0, 65535));
            1:       speed_in[i*CNT_W +: CNT_W] = 16'($urandom_range(0, 600));
            2:       speed_in[i*CNT_W +: CNT_W] = 16'($urandom_range(59000, 65535));
            default: speed_in[i*CNT_W +: CNT_W] = 16'($urandom_range(256, 60000));
          endcase
        end
      end
      if ($urandom_range(0, 2999) == 0) arm = ~arm;
      if (!arm && $urandom_range(0, 299) == 0) arm = 1'b1;
      if ($urandom_range(0, 7999) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    speed_valid = 1'b0;
    step();
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
